// File: rtl/mem_port_arbiter.sv
// Shares the single RAM port between instruction fetch and data access, inserting
// fixed wait states and forming byte enables / aligned read data for the data side.
module mem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_mfc,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [1:0]  d_size,
  input  logic        d_signed,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_mfc,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        owner_d;
  logic        last_d;
  logic [1:0]  lat_lo;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic        grant_d, grant_if;
  logic [3:0]  be_nx;
  logic [31:0] wd_nx;
  logic [31:0] rd_shift;
  logic [15:0] rd_half;
  logic [31:0] rd_al;
  logic        unused_if_lo;

  assign unused_if_lo = ^if_addr[1:0];

  // On contention D wins unless it took the previous grant.
  assign grant_d  = d_req && (!if_req || !last_d);
  assign grant_if = if_req && !grant_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_d || grant_if) state_nx = ACCESS;
      ACCESS:  if (cnt == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_en = (state == ACCESS);
    if_mfc = (state == DONE) && !owner_d;
    d_mfc  = (state == DONE) && owner_d;
  end

  always_comb begin
    be_nx = '1;
    wd_nx = d_wdata;
    case (d_size)
      2'b00: begin
        be_nx = 4'b0001 << d_addr[1:0];
        wd_nx = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        be_nx = d_addr[1] ? 4'b1100 : 4'b0011;
        wd_nx = {2{d_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_shift = mem_rdata >> {lat_lo, 3'b000};
    rd_half  = lat_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_size)
      2'b00:   rd_al = {{24{lat_signed & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rd_al = {{16{lat_signed & rd_half[15]}}, rd_half};
      default: rd_al = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      owner_d    <= 1'b0;
      last_d     <= 1'b0;
      lat_lo     <= '0;
      lat_size   <= '0;
      lat_signed <= 1'b0;
      mem_rw     <= 1'b1;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner_d    <= 1'b1;
            last_d     <= 1'b1;
            mem_addr   <= {d_addr[31:2], 2'b00};
            lat_lo     <= {d_addr[1], d_addr[0] & (d_size != 2'b01)};
            lat_size   <= d_size;
            lat_signed <= d_signed;
            mem_rw     <= d_rw;
            mem_be     <= be_nx;
            mem_wdata  <= wd_nx;
            cnt        <= 4'(WAIT_CYCLES);
          end else if (grant_if) begin
            owner_d    <= 1'b0;
            last_d     <= 1'b0;
            mem_addr   <= {if_addr[31:2], 2'b00};
            lat_lo     <= '0;
            lat_size   <= 2'b10;
            lat_signed <= 1'b0;
            mem_rw     <= 1'b1;
            mem_be     <= '1;
            mem_wdata  <= '0;
            cnt        <= 4'(WAIT_CYCLES);
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (mem_rw) begin
              if (owner_d) d_rdata  <= rd_al;
              else         if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: WAIT_CYCLES=2 main instance plus a
// WAIT_CYCLES=0 instance for the zero-wait-state timing.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        if_req = 0, d_req = 0, d_rw = 1, d_signed = 0;
  logic [1:0]  d_size = 2'b10;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_mfc, d_mfc, mem_en, mem_rw;
  logic [3:0]  mem_be;

  logic        if_req0 = 0;
  logic [31:0] if_addr0 = '0, mem_rdata0 = '0;
  logic [31:0] if_rdata0, d_rdata0, mem_addr0, mem_wdata0;
  logic        if_mfc0, d_mfc0, mem_en0, mem_rw0;
  logic [3:0]  mem_be0;

  mem_port_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_mfc(if_mfc), .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_signed(d_signed),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_mfc(d_mfc),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .if_req(if_req0), .if_addr(if_addr0), .if_rdata(if_rdata0),
    .if_mfc(if_mfc0), .d_req(1'b0), .d_rw(1'b1), .d_size(2'b10), .d_signed(1'b0),
    .d_addr(32'h0), .d_wdata(32'h0), .d_rdata(d_rdata0), .d_mfc(d_mfc0),
    .mem_en(mem_en0), .mem_rw(mem_rw0), .mem_addr(mem_addr0), .mem_be(mem_be0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
  );

  int checks = 0;
  int failures = 0;

  int          cyc, en_cyc;
  logic        stable;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_rw;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issued from IDLE with req already set; returns with the owner's mfc sampled high.
  task automatic wait_mfc(input bit is_d);
    cyc = 0; en_cyc = 0; stable = 1'b1;
    while (cyc < 20) begin
      tick();
      cyc++;
      if (is_d ? d_mfc : if_mfc) break;
      if (mem_en) begin
        if (en_cyc == 0) begin
          cap_addr = mem_addr; cap_be = mem_be; cap_rw = mem_rw; cap_wdata = mem_wdata;
        end else if (mem_addr !== cap_addr || mem_be !== cap_be ||
                     mem_rw !== cap_rw || mem_wdata !== cap_wdata) begin
          stable = 1'b0;
        end
        en_cyc++;
      end
    end
  endtask

  task automatic d_read(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    d_addr = a; d_size = sz; d_signed = sg; d_rw = 1'b1; d_req = 1'b1;
    wait_mfc(1'b1);
    d_req = 1'b0;
  endtask

  int own [0:7];
  int tim [0:7];
  int n_mfc, both_hi;
  logic [5:0] en_v, mfc_v;

  initial begin
    tick(); tick();
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_rw", {31'b0, mem_rw}, 32'd1);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mfc", {30'b0, if_mfc, d_mfc}, 32'h0);
    chk("rst_rdata", if_rdata | d_rdata, 32'h0);
    @(negedge clk) reset = 1'b0;
    tick();
    chk("idle_no_req", {31'b0, mem_en}, 32'd0);

    // IF fetch, two wait states
    mem_rdata = 32'hE3A01005; if_addr = 32'h100; if_req = 1'b1;
    wait_mfc(1'b0);
    if_req = 1'b0;
    chk("if_latency", cyc, 32'd4);
    chk("if_en_cycles", en_cyc, 32'd3);
    chk("if_addr", cap_addr, 32'h100);
    chk("if_be", {28'b0, cap_be}, 32'hF);
    chk("if_rw", {31'b0, cap_rw}, 32'd1);
    chk("if_stable", {31'b0, stable}, 32'd1);
    chk("if_rdata", if_rdata, 32'hE3A01005);
    tick();
    chk("if_mfc_pulse", {30'b0, if_mfc, mem_en}, 32'h0);

    // data reads with alignment and extension
    mem_rdata = 32'h8001_1234;
    d_read(32'h302, 2'b01, 1'b1); tick();
    chk("hw_s_be", {28'b0, cap_be}, 32'hC);
    chk("hw_s_addr", cap_addr, 32'h300);
    chk("hw_s_latency", cyc, 32'd4);
    chk("hw_s_rdata", d_rdata, 32'hFFFF8001);
    chk("d_mfc_pulse", {31'b0, d_mfc}, 32'd0);
    d_read(32'h302, 2'b01, 1'b0); tick();
    chk("hw_u_rdata", d_rdata, 32'h00008001);
    d_read(32'h303, 2'b01, 1'b0); tick();
    chk("hw_odd_be", {28'b0, cap_be}, 32'hC);
    d_read(32'h303, 2'b00, 1'b1); tick();
    chk("b_s_be", {28'b0, cap_be}, 32'h8);
    chk("b_s_rdata", d_rdata, 32'hFFFFFF80);
    d_read(32'h301, 2'b00, 1'b0); tick();
    chk("b_u_be", {28'b0, cap_be}, 32'h2);
    chk("b_u_rdata", d_rdata, 32'h00000012);

    // byte write must not disturb d_rdata
    d_addr = 32'h203; d_size = 2'b00; d_rw = 1'b0; d_wdata = 32'h000000AB; d_req = 1'b1;
    wait_mfc(1'b1);
    d_req = 1'b0;
    chk("bw_be", {28'b0, cap_be}, 32'h8);
    chk("bw_wdata", cap_wdata, 32'hABABABAB);
    chk("bw_rw", {31'b0, cap_rw}, 32'd0);
    chk("bw_addr", cap_addr, 32'h200);
    chk("bw_stable", {31'b0, stable}, 32'd1);
    chk("bw_rdata_kept", d_rdata, 32'h00000012);
    tick();

    // halfword write lane replication
    d_addr = 32'h206; d_size = 2'b01; d_rw = 1'b0; d_wdata = 32'hFFFF_5AA5; d_req = 1'b1;
    wait_mfc(1'b1);
    d_req = 1'b0;
    chk("hw_w_be", {28'b0, cap_be}, 32'hC);
    chk("hw_w_wdata", cap_wdata, 32'h5AA55AA5);
    tick();

    // reset during the second ACCESS cycle of a write
    d_addr = 32'h208; d_size = 2'b10; d_rw = 1'b0; d_wdata = 32'h1111_2222; d_req = 1'b1;
    tick(); tick();
    chk("pre_rst_en", {31'b0, mem_en}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("midrst_mfc", {30'b0, if_mfc, d_mfc}, 32'h0);
    chk("midrst_be", {28'b0, mem_be}, 32'h0);
    d_req = 1'b0;
    tick(); tick();
    chk("midrst_no_mfc", {30'b0, if_mfc, d_mfc}, 32'h0);
    @(negedge clk) reset = 1'b0;
    tick();
    mem_rdata = 32'hCAFE_F00D;
    d_read(32'h300, 2'b10, 1'b0);
    chk("post_rst_latency", cyc, 32'd4);
    chk("post_rst_rdata", d_rdata, 32'hCAFEF00D);
    tick();

    // contention: fresh fairness state, both requests held high
    @(negedge clk) reset = 1'b1;
    tick();
    @(negedge clk) reset = 1'b0;
    d_addr = 32'h400; d_size = 2'b10; d_rw = 1'b1; if_addr = 32'h500;
    if_req = 1'b1; d_req = 1'b1;
    n_mfc = 0; both_hi = 0;
    for (int t = 1; t <= 22; t++) begin
      tick();
      if (if_mfc && d_mfc) both_hi++;
      if ((if_mfc || d_mfc) && n_mfc < 8) begin
        own[n_mfc] = d_mfc ? 1 : 0;
        tim[n_mfc] = t;
        n_mfc++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("arb_count", n_mfc, 32'd4);
    chk("arb_both", both_hi, 32'd0);
    chk("arb_own0", own[0], 32'd1);
    chk("arb_own1", own[1], 32'd0);
    chk("arb_own2", own[2], 32'd1);
    chk("arb_own3", own[3], 32'd0);
    chk("arb_t0", tim[0], 32'd4);
    chk("arb_t3", tim[3], 32'd19);
    repeat (6) tick();
    chk("arb_idle", {31'b0, mem_en}, 32'd0);

    // zero wait states, back-to-back fetches
    mem_rdata0 = 32'h1234_5678; if_addr0 = 32'h40; if_req0 = 1'b1;
    en_v = '0; mfc_v = '0;
    for (int t = 0; t < 6; t++) begin
      tick();
      en_v[t] = mem_en0;
      mfc_v[t] = if_mfc0;
    end
    if_req0 = 1'b0;
    chk("w0_en_pattern", {26'b0, en_v}, 32'b001001);
    chk("w0_mfc_pattern", {26'b0, mfc_v}, 32'b010010);
    chk("w0_rdata", if_rdata0, 32'h12345678);
    chk("w0_addr", mem_addr0, 32'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single RAM port of the ARM datapath and shares it between two requesters: instruction fetch (IF) and the microprogrammed data access (D).
- Generates the per-requester memory-function-complete (mfc) that the control unit's microsequencer waits on.
- Inserts a fixed number of wait states.
- Forms byte enables and aligns byte/halfword read data, with optional sign extension.

Parameters:
- WAIT_CYCLES, 2, RAM read/write latency in cycles after mem_en first asserts; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held high until if_mfc
- if_addr  in  32  fetch byte address; word access, addr[1:0] ignored
- if_rdata  out  32  fetched word
- if_mfc  out  1  fetch complete, one-cycle pulse
- d_req  in  1  data request; held high until d_mfc
- d_rw  in  1  1 = read, 0 = write
- d_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- d_signed  in  1  sign-extend byte/halfword reads
- d_addr  in  32  data byte address
- d_wdata  in  32  write data, low-order aligned
- d_rdata  out  32  aligned/extended read data
- d_mfc  out  1  data complete, one-cycle pulse
- mem_en  out  1  RAM access enable
- mem_rw  out  1  1 = read, 0 = write
- mem_addr  out  32  word address: {addr[31:2], 2'b00}
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian)
- mem_wdata  out  32  write data replicated onto selected lanes
- mem_rdata  in  32  RAM read data

Behaviour:
- Reset values:
  - state IDLE
  - if_mfc = d_mfc = 0
  - mem_en = 0, mem_rw = 1, mem_addr = 0, mem_be = 0, mem_wdata = 0
  - if_rdata = d_rdata = 0
  - fairness bit last_d = 0
- Reset mid-access aborts immediately. No mfc is issued for the aborted access.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Arbitration is evaluated at each rising edge.
  - If only one request is high, grant it.
  - If both are high, grant D unless last_d = 1, in which case grant IF.
  - last_d <= 1 when D is granted, and <= 0 when IF is granted.
  - On grant, latch owner, address, size, rw and wdata into internal registers, load counter = WAIT_CYCLES, and go to ACCESS.
  - No request: remain in IDLE.
- ACCESS:
  - mem_en = 1; mem_addr, mem_rw, mem_be and mem_wdata are driven from the latched values and are stable for the whole access.
  - Counter decrements each cycle.
  - On the edge where counter == 0: capture read data (reads only) into the owner's rdata register and go to DONE.
  - ACCESS lasts WAIT_CYCLES+1 cycles.
- DONE:
  - Owner's mfc = 1 for exactly this one cycle; mem_en = 0.
  - Next state is always IDLE; requests are ignored in DONE.
  - The requester drops req on the edge ending DONE.
  - A req still high in IDLE is treated as a new request.
- Latency from the grant edge to mfc high is WAIT_CYCLES+1 cycles; each access occupies WAIT_CYCLES+3 cycles IDLE-to-IDLE.
- if_rdata and d_rdata hold their value until overwritten by the next read of the same owner. A write never alters d_rdata.
- Byte enables and write-data lanes:
  - Byte: mem_be = 1 << addr[1:0]; mem_wdata = {4{d_wdata[7:0]}}.
  - Halfword: addr[0] is forced to 0 (aligned down); mem_be = addr[1] ? 1100 : 0011; mem_wdata = {2{d_wdata[15:0]}}.
  - Word / reserved size: mem_be = 1111.
- Read alignment:
  - The selected byte or halfword is shifted to bits [7:0] or [15:0].
  - Upper bits are zero-filled, or filled with the MSB of the selected data when d_signed = 1.
- IF accesses: always word reads with mem_be = 1111.

Test Plan:
- WAIT_CYCLES=2; IF read of 0x100, mem_rdata=0xE3A01005 -> mem_en high 3 cycles with mem_addr=0x100, mem_be=1111; if_mfc pulses once, 3 cycles after the grant edge; if_rdata=0xE3A01005.
- D byte write, addr 0x203, d_wdata=0x000000AB -> mem_be=1000, mem_wdata=0xABABABAB, mem_rw=0, mem_addr=0x200; d_mfc one pulse; d_rdata unchanged.
- D signed halfword read, addr 0x302, mem_rdata=0x8001_1234 -> mem_be=1100, d_rdata=0xFFFF8001; repeat with d_signed=0 -> 0x00008001; byte addr 0x301 unsigned -> 0x00000012.
- if_req and d_req rise in the same cycle and both stay high through repeated requests -> grants alternate D, IF, D, IF; no two grants to the same owner while the other is waiting; no access is lost.
- WAIT_CYCLES=0 -> ACCESS lasts 1 cycle, mfc in the cycle after the grant edge, back-to-back accesses every 3 cycles.
- Assert reset during the 2nd ACCESS cycle of a D write -> mem_en, d_mfc and if_mfc drop immediately; FSM in IDLE; a re-issued request after reset completes normally.
